// File: rtl/lb_ctrl_pkg.sv
// Shared types and constants for the line-buffer frame sequencer.
package lb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  localparam int DEF_KERNEL_LENGTH = 3;
  localparam int DEF_DATA_WIDTH    = 32;

endpackage

// File: rtl/line_buffer_ctrl_window.sv
// KxK window register: each enable shifts every row one column left and
// loads the incoming K-pixel column into the newest column (K-1).
module window_shift_reg
  import lb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int KERNEL_LENGTH = DEF_KERNEL_LENGTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          shift_en,
  input  logic [KERNEL_LENGTH*DATA_WIDTH-1:0]           col_in,
  output logic [KERNEL_LENGTH*KERNEL_LENGTH*DATA_WIDTH-1:0] win_out
);

  localparam int K  = KERNEL_LENGTH;
  localparam int DW = DATA_WIDTH;

  logic [K*K*DW-1:0] win_q;
  logic [K*K*DW-1:0] win_d;

  // Cell (row gi, col gj) sits at flat index gi*K+gj; col 0 is the oldest.
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gj == K - 1) begin : g_new
        assign win_d[(gi*K+gj)*DW +: DW] = col_in[gi*DW +: DW];
      end else begin : g_old
        assign win_d[(gi*K+gj)*DW +: DW] = win_q[(gi*K+gj+1)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (shift_en) begin
      win_q <= win_d;
    end
  end

  assign win_out = win_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer: pops K-pixel columns from the line buffer, builds a KxK
// sliding window and emits strided windows with coordinates downstream.
module line_buffer_ctrl
  import lb_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int KERNEL_LENGTH = DEF_KERNEL_LENGTH,
  parameter int W_BITS        = 10,
  parameter int H_BITS        = 10
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [W_BITS-1:0]                                 img_width,
  input  logic [H_BITS-1:0]                                 img_height,
  input  logic [1:0]                                        stride,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              cfg_err,
  input  logic                                              lb_valid,
  input  logic [KERNEL_LENGTH*DATA_WIDTH-1:0]               lb_col,
  output logic                                              lb_ren,
  output logic                                              win_valid,
  input  logic                                              win_ready,
  output logic [KERNEL_LENGTH*KERNEL_LENGTH*DATA_WIDTH-1:0] win_data,
  output logic [H_BITS-1:0]                                 win_row,
  output logic [W_BITS-1:0]                                 win_col
);

  localparam logic [W_BITS-1:0] K_W   = W_BITS'(KERNEL_LENGTH);
  localparam logic [W_BITS-1:0] KM1_W = W_BITS'(KERNEL_LENGTH - 1);
  localparam logic [H_BITS-1:0] K_H   = H_BITS'(KERNEL_LENGTH);

  state_e              state_q, state_d;
  logic [W_BITS-1:0]   width_q, width_d;
  logic [H_BITS-1:0]   height_q, height_d;
  logic [1:0]          stride_q, stride_d;
  logic [W_BITS-1:0]   col_q, col_d;
  logic [H_BITS-1:0]   row_q, row_d;
  logic                win_valid_q, win_valid_d;
  logic [H_BITS-1:0]   win_row_q, win_row_d;
  logic [W_BITS-1:0]   win_col_q, win_col_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic                pop;
  logic                last_col;
  logic                emit;
  logic                bad_cfg;
  logic [W_BITS-1:0]   win_col_rel;

  assign lb_ren = (state_q == RUN) && (!win_valid_q || win_ready);
  assign pop    = lb_ren && lb_valid;

  assign last_col    = (col_q == width_q - W_BITS'(1));
  assign win_col_rel = col_q - KM1_W;
  // Stride 2 needs only even offsets, so a parity test replaces the modulo.
  assign emit = (col_q >= KM1_W) &&
                ((stride_q == STRIDE_1) || (!win_col_rel[0] && !row_q[0]));
  assign bad_cfg = (width_q < K_W) || (height_q < K_H) ||
                   ((stride_q != STRIDE_1) && (stride_q != STRIDE_2));

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = 1'b0;
    cfg_err_d   = cfg_err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          width_d   = img_width;
          height_d  = img_height;
          stride_d  = stride;
          cfg_err_d = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        col_d = '0;
        row_d = '0;
        if (bad_cfg) begin
          cfg_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pop && last_col && (row_q == height_q - K_H)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!win_valid_q || win_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop implies the previous window (if any) has retired this cycle.
    if (pop) begin
      win_valid_d = emit;
      if (emit) begin
        win_row_d = row_q;
        win_col_d = win_col_rel;
      end
      if (last_col) begin
        col_d = '0;
        row_d = row_q + H_BITS'(1);
      end else begin
        col_d = col_q + W_BITS'(1);
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  window_shift_reg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .KERNEL_LENGTH(KERNEL_LENGTH)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .shift_en(pop),
    .col_in  (lb_col),
    .win_out (win_data)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized scoreboard bench for line_buffer_ctrl: an image-level model
// predicts every window; a monitor checks each presented window against it.
module tb_line_buffer_ctrl;

  localparam int DW   = 32;
  localparam int K    = 3;
  localparam int WB   = 10;
  localparam int HB   = 10;
  localparam int MAXD = 16;
  localparam int VW   = K*K*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [WB-1:0]   img_width;
  logic [HB-1:0]   img_height;
  logic [1:0]      stride;
  logic            busy, done, cfg_err;
  logic            lb_valid, lb_ren;
  logic [K*DW-1:0] lb_col;
  logic            win_valid, win_ready;
  logic [VW-1:0]   win_data;
  logic [HB-1:0]   win_row;
  logic [WB-1:0]   win_col;

  always #5 clk = ~clk;

  line_buffer_ctrl #(
    .DATA_WIDTH(DW), .KERNEL_LENGTH(K), .W_BITS(WB), .H_BITS(HB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_width(img_width), .img_height(img_height), .stride(stride),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .lb_valid(lb_valid), .lb_col(lb_col), .lb_ren(lb_ren),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col)
  );

  typedef struct {
    int            row;
    int            col;
    logic [VW-1:0] data;
  } win_t;

  win_t          exp_q[$];
  logic [DW-1:0] img [MAXD][MAXD];
  int cfg_w = 0, cfg_s = 1;
  int vmode = 0, rmode = 0;
  int compared = 0, mismatched = 0;
  int pop_total = 0, ren_hi_total = 0, done_cnt = 0, win_seen = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Line-buffer model and downstream ready driver.
  initial begin : driver
    int  ptr, r, c, stall;
    bit  pend, pend_val;
    ptr = 0; stall = 0; pend = 0; pend_val = 0;
    lb_valid = 1'b0; lb_col = '0; win_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && !rst) chk("win_valid_after_pop", win_valid, pend_val);
      pend = 0;
      if (rst || !busy) ptr = 0;
      case (vmode)
        0:       lb_valid = 1'b1;
        1:       lb_valid = ~lb_valid;
        default: lb_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0: win_ready = 1'b1;
        1: win_ready = 1'($urandom_range(0, 1));
        default: begin
          if (win_valid) begin
            stall++;
            win_ready = (stall > 4);
            if (win_ready) stall = 0;
          end else begin
            win_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
      if (cfg_w > 0) begin
        r = ptr / cfg_w;
        c = ptr % cfg_w;
        for (int i = 0; i < K; i++) lb_col[i*DW +: DW] = img[(r+i) % MAXD][c % MAXD];
      end
      #1;
      if (lb_ren) ren_hi_total++;
      if (lb_ren && lb_valid && !rst && cfg_w > 0) begin
        r = ptr / cfg_w;
        c = ptr % cfg_w;
        pend     = 1;
        pend_val = (c >= K-1) && (((c-(K-1)) % cfg_s) == 0) && ((r % cfg_s) == 0);
        pop_total++;
        ptr++;
      end
    end
  end

  // Monitor: compares presented windows with the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (done) done_cnt++;
      if (win_valid && !win_ready) chk("no_pop_while_stalled", VW'(lb_ren), VW'(0));
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", VW'(win_valid), VW'(0));
        end else begin
          chk("win_row", VW'(win_row), VW'(exp_q[0].row));
          chk("win_col", VW'(win_col), VW'(exp_q[0].col));
          chk("win_data", win_data, exp_q[0].data);
          if (win_ready) begin
            $display("window accepted row=%0d col=%0d", win_row, win_col);
            void'(exp_q.pop_front());
            win_seen++;
          end
        end
      end
    end
  end

  task automatic load_image();
    for (int y = 0; y < MAXD; y++)
      for (int x = 0; x < MAXD; x++) img[y][x] = $urandom;
  endtask

  task automatic build_expected(input int w, input int h, input int s);
    win_t e;
    for (int r = 0; r <= h - K; r += s)
      for (int c = 0; c <= w - K; c += s) begin
        e.row = r; e.col = c; e.data = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) e.data[(i*K+j)*DW +: DW] = img[r+i][c+j];
        exp_q.push_back(e);
      end
  endtask

  task automatic run_frame(input int w, input int h, input int s,
                           input int vm, input int rm, input bit keep_img);
    int p0, d0, n0, r0, n_exp, cyc;
    bit bad;
    if (!keep_img) load_image();
    bad = (w < K) || (h < K) || !(s == 1 || s == 2);
    cfg_w = w; cfg_s = (s == 0) ? 1 : s; vmode = vm; rmode = rm;
    if (!bad) build_expected(w, h, s);
    n_exp = exp_q.size();
    p0 = pop_total; d0 = done_cnt; n0 = win_seen; r0 = ren_hi_total;
    $display("frame start w=%0d h=%0d stride=%0d vmode=%0d rmode=%0d", w, h, s, vm, rm);
    @(negedge clk);
    img_width = WB'(w); img_height = HB'(h); stride = 2'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_check", VW'(busy), VW'(1));
    chk("cfg_err_cleared_on_start", VW'(cfg_err), VW'(0));
    @(negedge clk);
    if (bad) begin
      chk("cfg_done_pulse", VW'(done), VW'(1));
      chk("cfg_err_set", VW'(cfg_err), VW'(1));
      chk("cfg_busy_low", VW'(busy), VW'(0));
      repeat (3) @(negedge clk);
      chk("cfg_lb_ren_never", VW'(ren_hi_total - r0), VW'(0));
      chk("cfg_done_count", VW'(done_cnt - d0), VW'(1));
      chk("cfg_err_sticky", VW'(cfg_err), VW'(1));
    end else begin
      cyc = 0;
      while (!done && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      chk("frame_done_seen", VW'(done), VW'(1));
      chk("busy_low_at_done", VW'(busy), VW'(0));
      repeat (3) @(negedge clk);
      chk("pop_count", VW'(pop_total - p0), VW'(w*(h-K+1)));
      chk("window_count", VW'(win_seen - n0), VW'(n_exp));
      chk("done_count", VW'(done_cnt - d0), VW'(1));
      chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
      chk("cfg_err_low", VW'(cfg_err), VW'(0));
    end
    $display("frame end w=%0d h=%0d stride=%0d", w, h, s);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, VW'(busy), VW'(0));
    chk({tag, "_done"}, VW'(done), VW'(0));
    chk({tag, "_cfg_err"}, VW'(cfg_err), VW'(0));
    chk({tag, "_lb_ren"}, VW'(lb_ren), VW'(0));
    chk({tag, "_win_valid"}, VW'(win_valid), VW'(0));
    chk({tag, "_win_data"}, win_data, VW'(0));
    chk({tag, "_win_row"}, VW'(win_row), VW'(0));
    chk({tag, "_win_col"}, VW'(win_col), VW'(0));
  endtask

  task automatic reset_mid_run();
    int d0;
    load_image();
    cfg_w = 5; cfg_s = 1; vmode = 0; rmode = 0;
    build_expected(5, 5, 1);
    d0 = done_cnt;
    $display("reset mid-run test");
    @(negedge clk);
    img_width = WB'(5); img_height = HB'(5); stride = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #3 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", VW'(done_cnt - d0), VW'(0));
    chk("idle_after_reset", VW'(busy), VW'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 1'b1; start = 1'b0; img_width = '0; img_height = '0; stride = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(5, 5, 1, 0, 0, 0);
    run_frame(7, 7, 2, 0, 0, 0);
    run_frame(5, 5, 1, 0, 2, 0);
    run_frame(4, 3, 1, 0, 0, 0);
    run_frame(4, 3, 1, 1, 0, 1);
    run_frame(2, 5, 1, 0, 0, 0);
    run_frame(5, 5, 3, 0, 0, 0);
    run_frame(5, 2, 1, 0, 0, 0);
    run_frame(5, 5, 1, 2, 1, 0);
    reset_mid_run();
    run_frame(5, 5, 1, 0, 0, 0);
    run_frame(3, 3, 1, 2, 1, 0);
    for (int n = 0; n < 6; n++)
      run_frame($urandom_range(3, 10), $urandom_range(3, 8), $urandom_range(1, 2), 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Frame-level sequencer for the K-row line buffer (split / ring_buffer chain).
- Pops one K-pixel column per handshake from the line buffer and assembles a KxK sliding window in a register.
- Tracks column/row position, applies stride, and emits windows with coordinates to the downstream MAC array over a valid/ready interface.
- Signals frame completion; rejects bad configurations.

Parameters:
- DATA_WIDTH, 32, pixel width.
- KERNEL_LENGTH, 3, kernel side K (window is KxK).
- W_BITS, 10, width of image-width and column counters.
- H_BITS, 10, width of image-height and row counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin frame; sampled only in IDLE.
- img_width  in  W_BITS  columns per row; latched on accepted start.
- img_height  in  H_BITS  rows per frame; latched on accepted start.
- stride  in  2  window stride; legal values 1 and 2; latched on start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of frame.
- cfg_err  out  1  sticky config error; cleared by the next accepted start.
- lb_valid  in  1  line buffer has a column available (its valid).
- lb_col  in  KERNEL_LENGTH*DATA_WIDTH  column; index 0 = oldest row.
- lb_ren  out  1  pop request; a pop occurs when lb_ren && lb_valid.
- win_valid  out  1  window available.
- win_ready  in  1  downstream accepts.
- win_data  out  K*K*DATA_WIDTH  window, [row][col]; col 0 = oldest column.
- win_row  out  H_BITS  output row index (pre-stride row count).
- win_col  out  W_BITS  window left-column index.

Behaviour:
- Reset: state IDLE; all outputs 0; counters and window register cleared. Reset mid-frame abandons the frame with no done pulse.
- States:
  - IDLE -> CHECK on start.
  - CHECK (1 cycle): if img_width<K, img_height<K, or stride not in {1,2}, then set cfg_err, pulse done, go to IDLE. Otherwise go to RUN.
  - RUN -> DRAIN after the pop of the final column (col=img_width-1, row=img_height-K).
  - DRAIN -> IDLE once win_valid is low or the final window is accepted; done pulses in the cycle the state returns to IDLE.
- busy = state != IDLE. A start while busy is ignored.
- lb_ren = (state==RUN) && (!win_valid || win_ready). The block never pops while a window is stalled.
- On each pop:
  - window register shifts one column (new column enters at col K-1).
  - col_cnt increments; at img_width-1 it wraps to 0 and row_cnt increments.
  - Total pops per frame = img_width*(img_height-K+1).
- Window emission, registered (win_valid rises the cycle after the completing pop):
  - condition: col_cnt_at_pop >= K-1, (col_cnt_at_pop-(K-1)) % stride == 0, and row_cnt % stride == 0.
  - win_col = col_cnt_at_pop-(K-1); win_row = row_cnt.
  - Columns from the previous row are never combined: validity depends on col_cnt after the wrap, so no flush cycle is needed.
- Hold rule: win_valid, win_data, win_row and win_col stay stable while win_valid && !win_ready.
- If win_ready is high in the same cycle as a new completing pop, the old window retires and the new one loads; there are no bubbles.
- stride=2 is implemented as a parity test on the counters; no divider.
- Counters are unsigned; comparisons use latched config. img_width=K gives one window per emitted row.

Decomposition:
- Package lb_ctrl_pkg:
  - state enum {IDLE, CHECK, RUN, DRAIN}.
  - STRIDE_1/STRIDE_2 constants.
  - default KERNEL_LENGTH and DATA_WIDTH.
- Sub-module window_shift_reg (KxK register, shift on enable, parallel read).

Test Plan:
- width=5, height=5, stride=1, lb_valid=1, win_ready=1 -> 15 pops; 9 windows; first win_valid the cycle after the 3rd pop with (row,col)=(0,0); last is (2,2); done one pulse; busy low after.
- width=7, height=7, stride=2 -> 35 pops; 9 windows at rows {0,2,4} x cols {0,2,4}; no window with odd row/col.
- win_ready low 4 cycles while win_valid -> lb_ren=0; zero pops; win_data/win_row/win_col unchanged; releases with the next window the following cycle.
- lb_valid toggling 1/0 with width=4, height=3 -> pops only when lb_valid; 2 windows with the same pixel contents as the no-gap run.
- start with width=2 (or stride=3) -> cfg_err=1, done pulse 2 cycles after start, lb_ren never high; next valid start clears cfg_err.
- rst asserted mid-RUN -> outputs 0 immediately; no done pulse; a subsequent start of 5x5 completes normally with 9 windows.
